// File: rtl/banked_line_buffer.sv
// banked_line_buffer: single-clock ring of NUM_BANKS line buffers.
// The producer fills the back bank (wr_ptr) and commits it; the consumer reads
// the oldest committed front bank (rd_ptr) and releases it. Sticky error flags
// record writes/commits into a full ring and reads/releases from an empty one.
module banked_line_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int LANE_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_BANKS  = 2,
    localparam int LANES     = DATA_WIDTH / LANE_WIDTH,
    localparam int BANK_BITS = (NUM_BANKS > 2) ? $clog2(NUM_BANKS) : 1,
    localparam int CNT_BITS  = $clog2(NUM_BANKS + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [LANES-1:0]      write_strobe,
    input  logic                  write_commit,
    output logic                  write_ready,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    input  logic                  read_enable,
    input  logic                  read_release,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  read_valid,
    output logic                  front_valid,
    output logic [CNT_BITS-1:0]   committed_count,
    output logic [BANK_BITS-1:0]  front_bank,
    output logic [BANK_BITS-1:0]  back_bank,
    output logic                  write_overrun,
    output logic                  read_underrun
);

    localparam int MEM_DEPTH = NUM_BANKS * (2 ** ADDR_WIDTH);
    localparam int MEM_AW    = BANK_BITS + ADDR_WIDTH;

    logic [BANK_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [BANK_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_BITS-1:0]  count_q, count_d;
    logic                 read_valid_q, read_valid_d;
    logic                 write_overrun_q, write_overrun_d;
    logic                 read_underrun_q, read_underrun_d;
    // Set by the first accepted read; gates the RAM output register so that
    // read_data is zero after reset without resetting the RAM itself.
    logic                 has_read_q, has_read_d;

    logic                 do_write;
    logic                 do_commit;
    logic                 do_read;
    logic                 do_release;
    logic [MEM_AW-1:0]    wr_index;
    logic [MEM_AW-1:0]    rd_index;

    // Ring increment that wraps at NUM_BANKS, which need not be a power of two.
    function automatic logic [BANK_BITS-1:0] next_ptr(input logic [BANK_BITS-1:0] p);
        return (p == BANK_BITS'(NUM_BANKS - 1)) ? '0 : p + 1'b1;
    endfunction

    assign write_ready     = (count_q != CNT_BITS'(NUM_BANKS));
    assign front_valid     = (count_q != '0);
    assign committed_count = count_q;
    assign front_bank      = rd_ptr_q;
    assign back_bank       = wr_ptr_q;
    assign read_valid      = read_valid_q;
    assign write_overrun   = write_overrun_q;
    assign read_underrun   = read_underrun_q;

    // Accepted operations; clear suppresses everything in its cycle.
    assign do_write   = !clear && write_ready && (|write_strobe);
    assign do_commit  = !clear && write_ready && write_commit;
    assign do_read    = !clear && front_valid && read_enable;
    assign do_release = !clear && front_valid && read_release;

    // Bank occupies the upper address bits; ring invariants keep the read and
    // write banks distinct whenever both ports are allowed to operate.
    assign wr_index = {wr_ptr_q, write_addr};
    assign rd_index = {rd_ptr_q, read_addr};

    // Next-state for pointers, occupancy, read-valid and the sticky error flags.
    always_comb begin
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        count_d         = count_q;
        read_valid_d    = 1'b0;
        write_overrun_d = write_overrun_q;
        read_underrun_d = read_underrun_q;
        has_read_d      = has_read_q;
        if (clear) begin
            wr_ptr_d        = '0;
            rd_ptr_d        = '0;
            count_d         = '0;
            write_overrun_d = 1'b0;
            read_underrun_d = 1'b0;
        end else begin
            read_valid_d = do_read;
            has_read_d   = has_read_q | do_read;
            if (do_commit) begin
                wr_ptr_d = next_ptr(wr_ptr_q);
            end
            if (do_release) begin
                rd_ptr_d = next_ptr(rd_ptr_q);
            end
            case ({do_commit, do_release})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (!write_ready && ((|write_strobe) || write_commit)) begin
                write_overrun_d = 1'b1;
            end
            if (!front_valid && (read_enable || read_release)) begin
                read_underrun_d = 1'b1;
            end
        end
    end

    // Bookkeeping registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            read_valid_q    <= 1'b0;
            write_overrun_q <= 1'b0;
            read_underrun_q <= 1'b0;
            has_read_q      <= 1'b0;
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            read_valid_q    <= read_valid_d;
            write_overrun_q <= write_overrun_d;
            read_underrun_q <= read_underrun_d;
            has_read_q      <= has_read_d;
        end
    end

    // One RAM per strobe lane so each maps to a plain single-write-port block RAM.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [LANE_WIDTH-1:0] mem [MEM_DEPTH];
            logic [LANE_WIDTH-1:0] rd_word_q;

            // Lane write port and registered read port; contents are never reset.
            always_ff @(posedge clk) begin
                if (do_write && write_strobe[gi]) begin
                    mem[wr_index] <= write_data[gi*LANE_WIDTH +: LANE_WIDTH];
                end
                if (do_read) begin
                    rd_word_q <= mem[rd_index];
                end
            end

            assign read_data[gi*LANE_WIDTH +: LANE_WIDTH] = has_read_q ? rd_word_q : '0;
        end
    endgenerate

endmodule

// File: tb/tb_banked_line_buffer.sv
// Randomized scoreboard bench for banked_line_buffer (3 banks, exercises the
// non-power-of-two wrap). A reference model tracks banks as a 2-D array and
// the ring with plain modulo arithmetic; read results are queued and checked
// by an independent monitor when read_valid appears.
module tb_banked_line_buffer;

    localparam int NB    = 3;
    localparam int DW    = 16;
    localparam int AW    = 8;
    localparam int LANES = 2;
    localparam int BB    = 2;
    localparam int CB    = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          clear;
    logic [AW-1:0] write_addr;
    logic [DW-1:0] write_data;
    logic [LANES-1:0] write_strobe;
    logic          write_commit;
    logic          write_ready;
    logic [AW-1:0] read_addr;
    logic          read_enable;
    logic          read_release;
    logic [DW-1:0] read_data;
    logic          read_valid;
    logic          front_valid;
    logic [CB-1:0] committed_count;
    logic [BB-1:0] front_bank;
    logic [BB-1:0] back_bank;
    logic          write_overrun;
    logic          read_underrun;

    banked_line_buffer #(
        .DATA_WIDTH(DW), .LANE_WIDTH(8), .ADDR_WIDTH(AW), .NUM_BANKS(NB)
    ) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .write_addr(write_addr), .write_data(write_data),
        .write_strobe(write_strobe), .write_commit(write_commit),
        .write_ready(write_ready), .read_addr(read_addr),
        .read_enable(read_enable), .read_release(read_release),
        .read_data(read_data), .read_valid(read_valid),
        .front_valid(front_valid), .committed_count(committed_count),
        .front_bank(front_bank), .back_bank(back_bank),
        .write_overrun(write_overrun), .read_underrun(read_underrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    logic [DW-1:0] m_mem [NB][256];
    int            m_wr, m_rd, m_cnt;
    bit            m_ovr, m_unr, m_rvalid;
    logic [DW-1:0] m_rdata;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_wr = 0; m_rd = 0; m_cnt = 0;
        m_ovr = 0; m_unr = 0; m_rvalid = 0;
        m_rdata = '0;
    endtask

    task automatic check_status();
        check("write_ready",     32'(write_ready),     32'(m_cnt != NB));
        check("front_valid",     32'(front_valid),     32'(m_cnt != 0));
        check("committed_count", 32'(committed_count), 32'(m_cnt));
        check("front_bank",      32'(front_bank),      32'(m_rd));
        check("back_bank",       32'(back_bank),       32'(m_wr));
        check("write_overrun",   32'(write_overrun),   32'(m_ovr));
        check("read_underrun",   32'(read_underrun),   32'(m_unr));
        check("read_valid",      32'(read_valid),      32'(m_rvalid));
        check("read_data",       32'(read_data),       32'(m_rdata));
    endtask

    // Check current state, predict the effect of the driven inputs, clock once.
    task automatic do_cycle();
        int nwr, nrd, ncnt;
        bit wok, rok, n_ovr, n_unr, n_rvalid;
        logic [DW-1:0] n_rdata;
        check_status();
        wok = (m_cnt != NB);
        rok = (m_cnt != 0);
        nwr = m_wr; nrd = m_rd; ncnt = m_cnt;
        n_ovr = m_ovr; n_unr = m_unr; n_rvalid = 0; n_rdata = m_rdata;
        if (clear) begin
            nwr = 0; nrd = 0; ncnt = 0; n_ovr = 0; n_unr = 0;
        end else begin
            if (read_enable) begin
                if (rok) begin
                    n_rdata  = m_mem[m_rd][read_addr];
                    n_rvalid = 1;
                    exp_q.push_back('{data: n_rdata, cyc: cyc + 1});
                end else n_unr = 1;
            end
            if (write_strobe != '0) begin
                if (wok) begin
                    for (int l = 0; l < LANES; l++)
                        if (write_strobe[l])
                            m_mem[m_wr][write_addr][l*8 +: 8] = write_data[l*8 +: 8];
                end else n_ovr = 1;
            end
            if (write_commit) begin
                if (wok) begin nwr = (m_wr + 1) % NB; ncnt++; end
                else n_ovr = 1;
            end
            if (read_release) begin
                if (rok) begin nrd = (m_rd + 1) % NB; ncnt--; end
                else n_unr = 1;
            end
        end
        @(posedge clk);
        #1;
        m_wr = nwr; m_rd = nrd; m_cnt = ncnt;
        m_ovr = n_ovr; m_unr = n_unr; m_rvalid = n_rvalid; m_rdata = n_rdata;
    endtask

    task automatic drive(input logic [1:0] s, input logic [7:0] wa, input logic [15:0] wd,
                         input logic cm, input logic re, input logic [7:0] ra,
                         input logic rl, input logic cl);
        write_strobe = s; write_addr = wa; write_data = wd; write_commit = cm;
        read_enable = re; read_addr = ra; read_release = rl; clear = cl;
        do_cycle();
    endtask

    task automatic idle();
        drive(2'b00, 8'd0, 16'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    endtask

    // Monitor: every read_valid pulse must match the oldest predicted read.
    always @(negedge clk) begin
        if (read_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_read @cyc %0d: got read_valid=1 data %h, expected no read",
                         cyc, read_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("[TB] read @cyc %0d data=%h", cyc, read_data);
                check("read_latency", 32'(cyc), 32'(e.cyc));
                check("sb_read_data", 32'(read_data), 32'(e.data));
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        clear = 0; write_addr = '0; write_data = '0; write_strobe = '0;
        write_commit = 0; read_addr = '0; read_enable = 0; read_release = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Idle after reset, then a read from an empty ring.
        idle();
        drive(2'b00, 8'd0, 16'd0, 1'b0, 1'b1, 8'd5, 1'b0, 1'b0);
        idle();

        // Fill every bank completely (last write shares a cycle with commit).
        for (int b = 0; b < NB; b++)
            for (int a = 0; a < 256; a++)
                drive(2'b11, 8'(a), 16'($urandom), 1'(a == 255), 1'b0, 8'd0, 1'b0, 1'b0);
        // Full: write and commit must be rejected, overrun raised.
        drive(2'b11, 8'd0, 16'hDEAD, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
        idle();
        // Drain with a read in the same cycle as each release.
        for (int b = 0; b < NB; b++)
            drive(2'b00, 8'd0, 16'd0, 1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0);
        // Release from empty raises underrun.
        drive(2'b00, 8'd0, 16'd0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
        drive(2'b00, 8'd0, 16'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1);

        // Directed: basic write/commit/read, lane strobes, commit+release+read.
        drive(2'b11, 8'd3, 16'h1234, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        drive(2'b00, 8'd0, 16'd0,    1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
        drive(2'b00, 8'd0, 16'd0,    1'b0, 1'b1, 8'd3, 1'b0, 1'b0);
        drive(2'b11, 8'd7, 16'hAAAA, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        drive(2'b01, 8'd7, 16'h55FF, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        drive(2'b00, 8'd0, 16'd0,    1'b1, 1'b1, 8'd3, 1'b1, 1'b0);
        drive(2'b00, 8'd0, 16'd0,    1'b0, 1'b1, 8'd7, 1'b0, 1'b0);
        // Commit/release pairs at count=1 walk both pointers around the ring.
        drive(2'b00, 8'd0, 16'd0,    1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++)
            drive(2'b11, 8'd9, 16'($urandom), 1'b1, 1'b1, 8'd9, 1'(k != 0), 1'b0);
        // Clear mid-fill with every other request asserted.
        drive(2'b11, 8'd1, 16'hBEEF, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        drive(2'b11, 8'd2, 16'hCAFE, 1'b1, 1'b1, 8'd1, 1'b1, 1'b1);
        idle();

        // Randomized traffic on a small address window to get frequent hits.
        for (int k = 0; k < 3000; k++)
            drive($urandom_range(0, 1) ? 2'($urandom) : 2'b00,
                  8'($urandom_range(0, 15)), 16'($urandom),
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 15)), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 79) == 0));

        // Asynchronous reset asserted mid-cycle takes effect without a clock edge.
        idle();
        write_strobe = 2'b11; write_commit = 1'b1; read_enable = 1'b1;
        #3 reset_n = 1'b0;
        model_reset();
        #1 check_status();
        @(posedge clk);
        #1 reset_n = 1'b1;
        idle();
        idle();

        check("pending_reads", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/banked_line_buffer.md
Name: banked_line_buffer

Overview:
- Single-clock, N-bank ring of line buffers for the graphics core.
- A producer (renderer) fills one back bank, then commits it. A consumer (scanout) reads the oldest committed front bank, then releases it.
- Successor to the two-clock single-bank buffer. Adds bank count, per-lane write strobes, registered read-valid, a flush, and sticky error flags.

Parameters:
- DATA_WIDTH, 16, word width in bits; must be a multiple of LANE_WIDTH.
- LANE_WIDTH, 8, bits per write-strobe lane.
- ADDR_WIDTH, 8, word address width; each bank holds 2**ADDR_WIDTH words.
- NUM_BANKS, 2, bank count; must be at least 2; need not be a power of two.
- Derived: LANES = DATA_WIDTH/LANE_WIDTH; BANK_BITS = max(1, clog2(NUM_BANKS)); CNT_BITS = clog2(NUM_BANKS+1).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush of bank bookkeeping.
- write_addr  in  ADDR_WIDTH  word address in the back bank.
- write_data  in  DATA_WIDTH  write word.
- write_strobe  in  LANES  per-lane write enable; lane i covers bits [i*LANE_WIDTH +: LANE_WIDTH].
- write_commit  in  1  pulse: back bank complete.
- write_ready  out  1  a back bank is available (combinational from state).
- read_addr  in  ADDR_WIDTH  word address in the front bank.
- read_enable  in  1  request a read.
- read_release  in  1  pulse: front bank consumed.
- read_data  out  DATA_WIDTH  registered read word.
- read_valid  out  1  read_data updated this cycle.
- front_valid  out  1  at least one committed bank exists.
- committed_count  out  CNT_BITS  committed, unreleased banks (0..NUM_BANKS).
- front_bank  out  BANK_BITS  index of the bank being read.
- back_bank  out  BANK_BITS  index of the bank being written.
- write_overrun  out  1  sticky error flag.
- read_underrun  out  1  sticky error flag.

Behaviour:
- State:
  - wr_ptr, rd_ptr in 0..NUM_BANKS-1; increment wraps NUM_BANKS-1 -> 0.
  - count in 0..NUM_BANKS.
  - front_bank = rd_ptr; back_bank = wr_ptr.
- Status outputs:
  - write_ready = (count != NUM_BANKS).
  - front_valid = (count != 0).
  - committed_count = count.
- Reset (reset_n low, asynchronous):
  - wr_ptr, rd_ptr, count = 0.
  - read_data = 0, read_valid = 0.
  - Both error flags = 0.
  - Memory is not reset.
- clear (synchronous, highest priority after reset):
  - Same register values as reset, except read_data holds its value.
  - All writes, reads, commits and releases in that cycle are ignored.
- Write: each lane with write_strobe[i]=1 is written to mem[wr_ptr][write_addr], only when write_ready=1.
  - Strobe lanes that are 0 keep their old contents.
  - Any strobe bit set while write_ready=0: no write; write_overrun set.
- Commit:
  - write_commit with write_ready=1: wr_ptr advances, count increments.
  - write_commit with write_ready=0: ignored; write_overrun set.
  - A write and a commit in the same cycle land in the pre-commit bank.
- Read:
  - read_enable with front_valid=1: read_data <= mem[rd_ptr][read_addr] on the next edge; read_valid=1 for that one cycle. Latency is 1.
  - Otherwise read_valid=0 and read_data holds.
  - read_enable with front_valid=0 sets read_underrun.
- Release:
  - read_release with front_valid=1: rd_ptr advances, count decrements.
  - read_release with front_valid=0: ignored; read_underrun set.
  - A read and a release in the same cycle use the pre-release bank.
- Simultaneous valid commit and release: both pointers advance; count is unchanged.
- Full boundary:
  - Commit at count = NUM_BANKS-1 makes write_ready=0.
  - A release in the same cycle as a commit, with count = NUM_BANKS, is not possible, because the commit is rejected on write_ready=0. The release alone proceeds.
- Hazards:
  - No read/write collision is possible: when count is between 1 and NUM_BANKS-1, wr_ptr != rd_ptr.
  - When count = 0, reads are blocked. When count = NUM_BANKS, writes are blocked.
- Error flags are sticky until reset or clear.
- Memory is inferable as block RAM: one write port, one registered read port.

Test Plan:
- Reset then idle:
  - All outputs are 0 except write_ready=1.
  - read_enable=1 at read_addr 5 -> read_valid stays 0 and read_underrun=1.
- Basic ping-pong with NUM_BANKS=2:
  - Write 0x1234 at addr 3 in bank 0, then commit -> count=1, front_bank=0, back_bank=1.
  - Read addr 3 -> next cycle read_data=0x1234, read_valid=1.
- Lane strobe:
  - Write 0xAAAA, strobe 2'b11, at addr 7; then 0x55FF, strobe 2'b01, at addr 7; commit.
  - Read addr 7 -> 0xAAFF.
- Full and overrun:
  - Commit twice with NUM_BANKS=2 -> write_ready=0, count=2.
  - A third commit and a write are ignored; write_overrun=1; pointers unchanged.
- Simultaneous commit and release at count=1:
  - count stays 1; front_bank 0->1; back_bank 1->0.
  - A read in the same cycle returns bank-0 data.
- Wrap with NUM_BANKS=3:
  - Perform 4 commit/release pairs -> pointers cycle 0,1,2,0,1.
  - Then clear mid-fill -> count=0, flags=0, pointers=0, read_data unchanged.
